// File: rtl/pic_wdt_reset_ctrl.sv
// Reset and watchdog source for the PIC16C57 core: POR pulse, synchronized MCLR,
// WDT base counter plus prescaler (postscaler when PSA=1), one-cycle WDT_timeout.
module pic_wdt_reset_ctrl #(
  parameter int WDT_BASE_CYCLES = 256,
  parameter int POR_HOLD_CYCLES = 16,
  parameter int BASE_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mclr_n_pin,
  input  logic       wdt_enable,
  input  logic       sleep,
  input  logic       clear_WDT,
  input  logic       clear_prescaler,
  input  logic [5:0] OPTION_out,
  output logic       POR,
  output logic       MCLR_rst,
  output logic       WDT_timeout,
  output logic [7:0] wdt_prescale_count
);
  localparam int HOLD_W = $clog2(POR_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_POR, S_MCLR, S_RUN} state_t;

  state_t            state;
  logic [BASE_W-1:0] base_cnt;
  logic [7:0]        presc;
  logic [HOLD_W-1:0] hold_cnt;
  logic              mclr_s1, mclr_s2;
  logic              psa, tick, ovf;
  logic [7:0]        presc_term;
  logic              unused_ok;

  // SLEEP never gates counting; a timeout while asleep is the wake event.
  assign unused_ok = &{1'b0, sleep, OPTION_out[5:4]};

  assign psa        = OPTION_out[3];
  assign presc_term = 8'((9'd1 << OPTION_out[2:0]) - 9'd1);
  assign tick       = (base_cnt == BASE_W'(WDT_BASE_CYCLES - 1));
  // >= so a PS shrink below the current count overflows on the next tick
  assign ovf        = tick & (~psa | (presc >= presc_term));

  assign wdt_prescale_count = presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclr_s1 <= 1'b1;
      mclr_s2 <= 1'b1;
    end else begin
      mclr_s1 <= mclr_n_pin;
      mclr_s2 <= mclr_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_POR;
      POR         <= 1'b1;
      MCLR_rst    <= 1'b0;
      WDT_timeout <= 1'b0;
      base_cnt    <= '0;
      presc       <= '0;
      hold_cnt    <= '0;
    end else begin
      WDT_timeout <= 1'b0;
      case (state)
        S_POR: begin
          base_cnt <= '0;
          presc    <= '0;
          if (hold_cnt == HOLD_W'(POR_HOLD_CYCLES)) begin
            POR   <= 1'b0;
            state <= S_RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_MCLR: begin
          base_cnt <= '0;
          presc    <= '0;
          if (mclr_s2) begin
            state    <= S_RUN;
            MCLR_rst <= 1'b0;
          end
        end
        S_RUN: begin
          if (!mclr_s2) begin
            state    <= S_MCLR;
            MCLR_rst <= 1'b1;
            base_cnt <= '0;
            presc    <= '0;
          end else if (!wdt_enable) begin
            base_cnt <= '0;
            presc    <= '0;
          end else if (clear_WDT || clear_prescaler) begin
            // Every clear combination leaves the prescaler at 0 (PSA=0 holds it there anyway).
            base_cnt <= clear_WDT ? '0 : (tick ? '0 : base_cnt + 1'b1);
            presc    <= '0;
          end else begin
            base_cnt    <= tick ? '0 : base_cnt + 1'b1;
            WDT_timeout <= ovf;
            if (!psa || ovf) presc <= '0;
            else if (tick)   presc <= presc + 1'b1;
          end
        end
        default: state <= S_POR;
      endcase
    end
  end
endmodule
